// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: merges the instruction-fetch and data-load read ports onto
// a single AXI read channel. Data reads have priority, one AR is in flight
// on the address channel at a time, and per-ID outstanding counters throttle
// acceptance. R beats are routed back by rid with zero latency.
module axi_rd_arbiter #(
    parameter int MAX_OUTST = 2,
    parameter int CNT_W     = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [1:0]  inst_size,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_rreq,
    input  logic [31:0] data_raddr,
    input  logic [1:0]  data_rsize,
    input  logic        data_wr_block,
    output logic        data_raddr_ok,
    output logic        data_rdata_ok,
    output logic [31:0] data_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZRO = {CNT_W{1'b0}};
    localparam logic [3:0]       ID_INST = 4'd0;
    localparam logic [3:0]       ID_DATA = 4'd1;

    state_t            state_q, state_d;
    logic              arvalid_q, arvalid_d;
    logic [3:0]        arid_q, arid_d;
    logic [31:0]       araddr_q, araddr_d;
    logic [1:0]        arsize_q, arsize_d;
    logic [CNT_W-1:0]  inst_cnt_q, inst_cnt_d;
    logic [CNT_W-1:0]  data_cnt_q, data_cnt_d;

    logic              rready_s;
    logic              beat_s;
    logic              inst_beat_s;
    logic              data_beat_s;
    logic              inst_dec_s;
    logic              data_dec_s;
    logic              inst_room_s;
    logic              data_room_s;
    logic              idle_s;
    logic              data_acc_s;
    logic              inst_acc_s;
    logic              unused_ok_s;

    // Response and AXI attributes that carry no information for single-beat reads.
    assign unused_ok_s = ^{rresp, rlast};

    // rready is low only while reset is asserted; every beat is consumed otherwise.
    assign rready_s    = ~reset;
    assign beat_s      = rvalid & rready_s;
    assign inst_beat_s = beat_s & (rid == ID_INST);
    assign data_beat_s = beat_s & (rid == ID_DATA);

    // A beat against an empty counter is a stray response and must not underflow.
    assign inst_dec_s  = inst_beat_s & (inst_cnt_q != CNT_ZRO);
    assign data_dec_s  = data_beat_s & (data_cnt_q != CNT_ZRO);

    // A slot freed by a same-cycle response may be reused immediately.
    assign inst_room_s = (inst_cnt_q < MAX_C) | inst_dec_s;
    assign data_room_s = (data_cnt_q < MAX_C) | data_dec_s;

    // Acceptance: one per cycle, only in IDLE, data before instruction.
    assign idle_s      = ~reset & (state_q == S_IDLE);
    assign data_acc_s  = idle_s & data_rreq & ~data_wr_block & data_room_s;
    assign inst_acc_s  = idle_s & ~data_acc_s & inst_req & inst_room_s;

    // AR channel next-state: latch the winner in IDLE, hold until the handshake.
    always_comb begin
        state_d   = state_q;
        arvalid_d = arvalid_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arsize_d  = arsize_q;
        case (state_q)
            S_IDLE: begin
                if (data_acc_s) begin
                    state_d   = S_HOLD;
                    arvalid_d = 1'b1;
                    arid_d    = ID_DATA;
                    araddr_d  = data_raddr;
                    arsize_d  = data_rsize;
                end else if (inst_acc_s) begin
                    state_d   = S_HOLD;
                    arvalid_d = 1'b1;
                    arid_d    = ID_INST;
                    araddr_d  = inst_addr;
                    arsize_d  = inst_size;
                end else begin
                    state_d   = S_IDLE;
                    arvalid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (arready) begin
                    state_d   = S_IDLE;
                    arvalid_d = 1'b0;
                end else begin
                    state_d   = S_HOLD;
                    arvalid_d = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                arvalid_d = 1'b0;
            end
        endcase
    end

    // Instruction outstanding counter: +1 on accept, -1 on a matching beat.
    always_comb begin
        inst_cnt_d = inst_cnt_q;
        case ({inst_acc_s, inst_dec_s})
            2'b10:   inst_cnt_d = inst_cnt_q + CNT_ONE;
            2'b01:   inst_cnt_d = inst_cnt_q - CNT_ONE;
            default: inst_cnt_d = inst_cnt_q;
        endcase
    end

    // Data outstanding counter: +1 on accept, -1 on a matching beat.
    always_comb begin
        data_cnt_d = data_cnt_q;
        case ({data_acc_s, data_dec_s})
            2'b10:   data_cnt_d = data_cnt_q + CNT_ONE;
            2'b01:   data_cnt_d = data_cnt_q - CNT_ONE;
            default: data_cnt_d = data_cnt_q;
        endcase
    end

    // State, AR registers and counters with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            arvalid_q  <= 1'b0;
            arid_q     <= 4'd0;
            araddr_q   <= 32'd0;
            arsize_q   <= 2'd0;
            inst_cnt_q <= CNT_ZRO;
            data_cnt_q <= CNT_ZRO;
        end else begin
            state_q    <= state_d;
            arvalid_q  <= arvalid_d;
            arid_q     <= arid_d;
            araddr_q   <= araddr_d;
            arsize_q   <= arsize_d;
            inst_cnt_q <= inst_cnt_d;
            data_cnt_q <= data_cnt_d;
        end
    end

    assign inst_addr_ok  = inst_acc_s;
    assign data_raddr_ok = data_acc_s;
    assign inst_data_ok  = inst_beat_s;
    assign data_rdata_ok = data_beat_s;
    assign inst_rdata    = rdata;
    assign data_rdata    = rdata;

    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arsize  = {1'b0, arsize_q};
    assign arvalid = arvalid_q;
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign rready  = rready_s;

endmodule
